// File: rtl/ecap5_dwbmmi.sv
// Single-transaction Wishbone B4 pipelined initiator with a request/done front end
// and a watchdog that aborts a cycle the responder never acknowledges.
module ecap5_dwbmmi #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_data_i,
   input  logic [3:0]  req_sel_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        wb_cyc_o,
   input  logic        wb_stall_i
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          ack_ok;
   logic          tmo_hit;

   // An ack only counts once the address phase has been (or is being) accepted.
   always_comb begin
      ack_ok  = 1'b0;
      tmo_hit = 1'b0;
      ack_ok  = wb_ack_i && ((state == REQ && !wb_stall_i) || state == WAIT);
      tmo_hit = (TIMEOUT != 0) && (state != IDLE) && (cnt == TMO) && !ack_ok;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         rdata_o  <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_we_o  <= 1'b0;
         wb_sel_o <= '0;
         wb_stb_o <= 1'b0;
         wb_cyc_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  wb_adr_o <= req_addr_i;
                  wb_dat_o <= req_data_i;
                  wb_we_o  <= req_we_i;
                  wb_sel_o <= req_sel_i;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  busy_o   <= 1'b1;
                  cnt      <= '0;
                  state    <= REQ;
               end
            end
            REQ, WAIT: begin
               if (ack_ok || tmo_hit) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  busy_o   <= 1'b0;
                  done_o   <= 1'b1;
                  err_o    <= tmo_hit;
                  state    <= IDLE;
                  if (tmo_hit)
                     rdata_o <= '0;
                  else if (!wb_we_o)
                     rdata_o <= wb_dat_i;
               end else begin
                  if (state == REQ && !wb_stall_i) begin
                     wb_stb_o <= 1'b0;
                     state    <= WAIT;
                  end
                  if (cnt != CNT_MAX)
                     cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
